// File: rtl/math_addsub_pipe_pkg.sv
// Shared math constants for the segmented add/sub pipeline: segment count,
// latency and the width legality check.
package math_addsub_pipe_pkg;

    function automatic int calc_nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic int calc_lat(input int width, input int seg_w);
        return calc_nseg(width, seg_w) + 1;
    endfunction

    function automatic bit width_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width > 0) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/math_addsub_pipe_shift_reg.sv
// Enable-gated delay line used for the operand skew, result deskew and
// valid pipelines; DEPTH=0 degenerates to a wire.
module shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign dout = din;
        end else begin : g_regs
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
                end else if (ena) begin
                    stages[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign dout = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/math_addsub_pipe.sv
// Carry-segmented pipelined adder/subtractor: one SEG_W slice per stage,
// operands skewed in and results deskewed out so full throughput is kept.
module math_addsub_pipe
    import math_addsub_pipe_pkg::*;
#(
    parameter int WIDTH  = 96,
    parameter int SEG_W  = 48,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             vld_in,
    input  logic             sub,
    input  logic [WIDTH-1:0] dina,
    input  logic [WIDTH-1:0] dinb,
    output logic [WIDTH:0]   dout,
    output logic             ovf,
    output logic             vld_out
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_W);
    localparam int LAT  = calc_lat(WIDTH, SEG_W);
    localparam int SKW  = 2 * SEG_W + 1;

    generate
        if (!width_ok(WIDTH, SEG_W)) begin : g_bad_width
            $error("math_addsub_pipe: WIDTH must be a positive multiple of SEG_W");
        end
    endgenerate

    logic [NSEG-1:0]  carry;
    logic [WIDTH-1:0] sum_aligned;
    logic             top_bit;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SKW-1:0]   skew_in;
        logic [SKW-1:0]   skew_out;
        logic             seg_sub;
        logic [SEG_W-1:0] seg_a;
        logic [SEG_W-1:0] seg_b;
        logic [SEG_W-1:0] seg_bx;
        logic [SEG_W:0]   seg_full;
        logic             cin;
        logic [SEG_W-1:0] sum_q;
        logic             carry_q;
        logic [SEG_W-1:0] sum_out;

        assign skew_in = {sub, dina[k*SEG_W +: SEG_W], dinb[k*SEG_W +: SEG_W]};

        if (k == 0) begin : g_noskew
            assign skew_out = skew_in;
        end else begin : g_skew
            shift_reg #(.WIDTH(SKW), .DEPTH(k)) u_skew (
                .clk(clk), .rst(rst), .ena(ena), .din(skew_in), .dout(skew_out)
            );
        end

        assign {seg_sub, seg_a, seg_b} = skew_out;
        assign seg_bx = seg_sub ? ~seg_b : seg_b;

        // Subtraction is a + ~b + 1, so the lowest segment takes sub as its carry-in.
        if (k == 0) begin : g_cin0
            assign cin = seg_sub;
        end else begin : g_cink
            assign cin = carry[k-1];
        end

        assign seg_full = {1'b0, seg_a} + {1'b0, seg_bx} + {{SEG_W{1'b0}}, cin};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (ena) begin
                sum_q   <= seg_full[SEG_W-1:0];
                carry_q <= seg_full[SEG_W];
            end
        end

        assign carry[k] = carry_q;

        // Bit WIDTH is the sum of the operands' extension bits plus the final carry.
        if (k == NSEG - 1) begin : g_top
            logic ext_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ext_q <= 1'b0;
                end else if (ena) begin
                    ext_q <= ((SIGNED != 0) ? seg_a[SEG_W-1] : 1'b0) ^
                             ((SIGNED != 0) ? seg_bx[SEG_W-1] : seg_sub);
                end
            end

            assign top_bit = ext_q ^ carry_q;
        end

        if (k == NSEG - 1) begin : g_nodeskew
            assign sum_out = sum_q;
        end else begin : g_deskew
            shift_reg #(.WIDTH(SEG_W), .DEPTH(NSEG - 1 - k)) u_deskew (
                .clk(clk), .rst(rst), .ena(ena), .din(sum_q), .dout(sum_out)
            );
        end

        assign sum_aligned[k*SEG_W +: SEG_W] = sum_out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            ovf  <= 1'b0;
        end else if (ena) begin
            dout <= {top_bit, sum_aligned};
            ovf  <= (SIGNED != 0) ? (top_bit ^ sum_aligned[WIDTH-1]) : top_bit;
        end
    end

    shift_reg #(.WIDTH(1), .DEPTH(LAT)) u_vld (
        .clk(clk), .rst(rst), .ena(ena), .din(vld_in), .dout(vld_out)
    );

endmodule

// File: tb/tb_math_addsub_pipe.sv
// Directed bench for math_addsub_pipe: unsigned/signed 96-bit instances plus
// 48-bit and 192-bit width variants sharing the control inputs.
module tb_math_addsub_pipe;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         vld_in;
    logic         sub;
    logic [95:0]  dina;
    logic [95:0]  dinb;
    logic [47:0]  dina48;
    logic [47:0]  dinb48;
    logic [191:0] dina192;
    logic [191:0] dinb192;

    logic [96:0]  dout_u;
    logic         ovf_u;
    logic         vld_u;
    logic [96:0]  dout_s;
    logic         ovf_s;
    logic         vld_s;
    logic [48:0]  dout_48;
    logic         ovf_48;
    logic         vld_48;
    logic [192:0] dout_192;
    logic         ovf_192;
    logic         vld_192;

    int checks;
    int failures;

    math_addsub_pipe #(.WIDTH(96), .SEG_W(48), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .vld_in(vld_in), .sub(sub),
        .dina(dina), .dinb(dinb), .dout(dout_u), .ovf(ovf_u), .vld_out(vld_u)
    );

    math_addsub_pipe #(.WIDTH(96), .SEG_W(48), .SIGNED(1)) u_sgn (
        .clk(clk), .rst(rst), .ena(ena), .vld_in(vld_in), .sub(sub),
        .dina(dina), .dinb(dinb), .dout(dout_s), .ovf(ovf_s), .vld_out(vld_s)
    );

    math_addsub_pipe #(.WIDTH(48), .SEG_W(48), .SIGNED(0)) u_w48 (
        .clk(clk), .rst(rst), .ena(ena), .vld_in(vld_in), .sub(sub),
        .dina(dina48), .dinb(dinb48), .dout(dout_48), .ovf(ovf_48), .vld_out(vld_48)
    );

    math_addsub_pipe #(.WIDTH(192), .SEG_W(48), .SIGNED(0)) u_w192 (
        .clk(clk), .rst(rst), .ena(ena), .vld_in(vld_in), .sub(sub),
        .dina(dina192), .dinb(dinb192), .dout(dout_192), .ovf(ovf_192), .vld_out(vld_192)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        vld_in  = 1'b0;
        sub     = 1'b0;
        dina    = '0;
        dinb    = '0;
        dina48  = '0;
        dinb48  = '0;
        dina192 = '0;
        dinb192 = '0;
    endtask

    task automatic flush(input int n);
        ena = 1'b1;
        clear_inputs();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++; if (dout_u !== 97'd0) begin failures++; $display("[TB] FAIL reset_dout got=%h exp=0", dout_u); end
        checks++; if (ovf_u !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", ovf_u); end
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld got=%b exp=0", vld_u); end
        checks++; if (vld_s !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld_sgn got=%b exp=0", vld_s); end
        checks++; if (vld_48 !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld_w48 got=%b exp=0", vld_48); end
        checks++; if (vld_192 !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld_w192 got=%b exp=0", vld_192); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned_add();
        dina   = 96'h0000FFFF_FFFFFFFF_FFFFFFFF;
        dinb   = 96'd1;
        sub    = 1'b0;
        vld_in = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL add_early_vld got=%b exp=0", vld_u); end
        tick();
        checks++; if (dout_u !== 97'h0_00010000_00000000_00000000) begin failures++; $display("[TB] FAIL add_dout got=%h exp=%h", dout_u, 97'h0_00010000_00000000_00000000); end
        checks++; if (ovf_u !== 1'b0) begin failures++; $display("[TB] FAIL add_ovf got=%b exp=0", ovf_u); end
        checks++; if (vld_u !== 1'b1) begin failures++; $display("[TB] FAIL add_vld got=%b exp=1", vld_u); end
        tick();
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL add_vld_pulse got=%b exp=0", vld_u); end
    endtask

    task automatic test_overflow_borrow();
        dina   = '1;
        dinb   = 96'd1;
        sub    = 1'b0;
        vld_in = 1'b1;
        tick();
        dina = '0;
        dinb = 96'd1;
        sub  = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (dout_u !== 97'h1_00000000_00000000_00000000) begin failures++; $display("[TB] FAIL carry_dout got=%h exp=%h", dout_u, 97'h1_00000000_00000000_00000000); end
        checks++; if (ovf_u !== 1'b1) begin failures++; $display("[TB] FAIL carry_ovf got=%b exp=1", ovf_u); end
        checks++; if (vld_u !== 1'b1) begin failures++; $display("[TB] FAIL carry_vld got=%b exp=1", vld_u); end
        tick();
        checks++; if (dout_u !== {97{1'b1}}) begin failures++; $display("[TB] FAIL borrow_dout got=%h exp=%h", dout_u, {97{1'b1}}); end
        checks++; if (ovf_u !== 1'b1) begin failures++; $display("[TB] FAIL borrow_ovf got=%b exp=1", ovf_u); end
        checks++; if (vld_u !== 1'b1) begin failures++; $display("[TB] FAIL borrow_vld got=%b exp=1", vld_u); end
        tick();
    endtask

    task automatic test_signed();
        logic [96:0] exp_neg8;
        exp_neg8 = 97'd0 - 97'd8;
        dina   = 96'h7FFFFFFF_FFFFFFFF_FFFFFFFF;
        dinb   = 96'd1;
        sub    = 1'b0;
        vld_in = 1'b1;
        tick();
        dina = 96'd0 - 96'd5;
        dinb = 96'd3;
        sub  = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (dout_s !== 97'h0_80000000_00000000_00000000) begin failures++; $display("[TB] FAIL sgn_ovf_dout got=%h exp=%h", dout_s, 97'h0_80000000_00000000_00000000); end
        checks++; if (ovf_s !== 1'b1) begin failures++; $display("[TB] FAIL sgn_ovf_flag got=%b exp=1", ovf_s); end
        tick();
        checks++; if (dout_s !== exp_neg8) begin failures++; $display("[TB] FAIL sgn_sub_dout got=%h exp=%h", dout_s, exp_neg8); end
        checks++; if (ovf_s !== 1'b0) begin failures++; $display("[TB] FAIL sgn_sub_ovf got=%b exp=0", ovf_s); end
        checks++; if (vld_s !== 1'b1) begin failures++; $display("[TB] FAIL sgn_sub_vld got=%b exp=1", vld_s); end
        tick();
    endtask

    task automatic test_stall();
        dina   = 96'h1234;
        dinb   = 96'h10;
        sub    = 1'b0;
        vld_in = 1'b1;
        ena    = 1'b1;
        tick();
        clear_inputs();
        ena = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL stall_vld_held_low got=%b exp=0", vld_u); end
        ena = 1'b1;
        tick();
        tick();
        checks++; if (dout_u !== 97'h1244) begin failures++; $display("[TB] FAIL stall_dout got=%h exp=1244", dout_u); end
        checks++; if (vld_u !== 1'b1) begin failures++; $display("[TB] FAIL stall_vld got=%b exp=1", vld_u); end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (dout_u !== 97'h1244) begin failures++; $display("[TB] FAIL stall_hold_dout got=%h exp=1244", dout_u); end
        checks++; if (vld_u !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold_vld got=%b exp=1", vld_u); end
        ena = 1'b1;
        tick();
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL stall_release_vld got=%b exp=0", vld_u); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 24;
        logic [97:0] exp_q[$];
        logic [97:0] exp_item;
        logic [96:0] res;
        logic        drv_done;
        logic        en_edge;
        int          got;
        int          cycles;
        drv_done = 1'b0;
        got      = 0;
        cycles   = 0;
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    int gaps;
                    gaps = $urandom_range(0, 2);
                    for (int g = 0; g < gaps; g++) begin
                        ena    = 1'($urandom_range(0, 1));
                        vld_in = 1'b0;
                        sub    = 1'($urandom_range(0, 1));
                        dina   = {$urandom, $urandom, $urandom};
                        dinb   = {$urandom, $urandom, $urandom};
                        tick();
                    end
                    ena    = 1'b1;
                    vld_in = 1'b1;
                    sub    = 1'($urandom_range(0, 1));
                    dina   = {$urandom, $urandom, $urandom};
                    dinb   = {$urandom, $urandom, $urandom};
                    if (i == 5) dina = '1;
                    if (sub) res = {1'b0, dina} - {1'b0, dinb};
                    else     res = {1'b0, dina} + {1'b0, dinb};
                    exp_q.push_back({res[96], res});
                    tick();
                end
                clear_inputs();
                ena = 1'b1;
                drv_done = 1'b1;
            end
            begin
                while (!(drv_done && got == N) && cycles < 600) begin
                    @(posedge clk);
                    en_edge = ena;
                    #1;
                    cycles++;
                    if (en_edge && vld_u) begin
                        if (exp_q.size() == 0) begin
                            checks++; failures++;
                            $display("[TB] FAIL b2b_extra_vld got=%h exp=none", dout_u);
                        end else begin
                            exp_item = exp_q.pop_front();
                            checks++; if (dout_u !== exp_item[96:0]) begin failures++; $display("[TB] FAIL b2b_dout idx=%0d got=%h exp=%h", got, dout_u, exp_item[96:0]); end
                            checks++; if (ovf_u !== exp_item[97]) begin failures++; $display("[TB] FAIL b2b_ovf idx=%0d got=%b exp=%b", got, ovf_u, exp_item[97]); end
                        end
                        got++;
                    end
                end
            end
        join
        checks++; if (got != N) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", got, N); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL b2b_pending got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_midstream();
        ena    = 1'b1;
        vld_in = 1'b1;
        sub    = 1'b0;
        dina   = 96'd5;  dinb = 96'd6;
        tick();
        dina   = 96'd100; dinb = 96'd1;
        tick();
        dina   = 96'd7;  dinb = 96'd8;
        tick();
        clear_inputs();
        checks++; if (dout_u !== 97'd11 || vld_u !== 1'b1) begin failures++; $display("[TB] FAIL mid_pre_reset got=%h/%b exp=%h/1", dout_u, vld_u, 97'd11); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dout_u !== 97'd0) begin failures++; $display("[TB] FAIL mid_rst_dout got=%h exp=0", dout_u); end
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_vld got=%b exp=0", vld_u); end
        checks++; if (ovf_u !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst_ovf got=%b exp=0", ovf_u); end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL mid_stale_vld cyc=%0d got=%b exp=0", i, vld_u); end
        end
        dina   = 96'd20;
        dinb   = 96'd22;
        vld_in = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (vld_u !== 1'b0) begin failures++; $display("[TB] FAIL mid_post_early got=%b exp=0", vld_u); end
        tick();
        checks++; if (dout_u !== 97'd42 || vld_u !== 1'b1) begin failures++; $display("[TB] FAIL mid_post_result got=%h/%b exp=%h/1", dout_u, vld_u, 97'd42); end
    endtask

    task automatic test_sweep();
        logic [192:0] exp192;
        exp192      = '0;
        exp192[192] = 1'b1;
        ena     = 1'b1;
        dina48  = '1;
        dinb48  = 48'd1;
        dina192 = '1;
        dinb192 = 192'd1;
        sub     = 1'b0;
        vld_in  = 1'b1;
        tick();
        clear_inputs();
        tick();
        checks++; if (dout_48 !== 49'h1_0000_0000_0000) begin failures++; $display("[TB] FAIL w48_dout got=%h exp=%h", dout_48, 49'h1_0000_0000_0000); end
        checks++; if (ovf_48 !== 1'b1 || vld_48 !== 1'b1) begin failures++; $display("[TB] FAIL w48_ovf_vld got=%b%b exp=11", ovf_48, vld_48); end
        checks++; if (vld_192 !== 1'b0) begin failures++; $display("[TB] FAIL w192_early2 got=%b exp=0", vld_192); end
        tick();
        checks++; if (vld_48 !== 1'b0) begin failures++; $display("[TB] FAIL w48_pulse got=%b exp=0", vld_48); end
        tick();
        checks++; if (vld_192 !== 1'b0) begin failures++; $display("[TB] FAIL w192_early4 got=%b exp=0", vld_192); end
        tick();
        checks++; if (dout_192 !== exp192) begin failures++; $display("[TB] FAIL w192_dout got=%h exp=%h", dout_192, exp192); end
        checks++; if (ovf_192 !== 1'b1 || vld_192 !== 1'b1) begin failures++; $display("[TB] FAIL w192_ovf_vld got=%b%b exp=11", ovf_192, vld_192); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        ena      = 1'b0;
        clear_inputs();
        test_reset();
        flush(6);
        test_unsigned_add();
        flush(6);
        test_overflow_borrow();
        flush(6);
        test_signed();
        flush(6);
        test_stall();
        flush(6);
        test_back_to_back();
        flush(6);
        test_reset_midstream();
        flush(8);
        test_sweep();
        flush(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
